scratch_mem_arbiter: RTL and testbench

SCRATCH_MEM_ARBITER -- requirements
Module: scratch_mem_arbiter

---
 rtl/scratch_mem_arbiter_pkg.sv | 15 +
 rtl/scratch_arb_select.sv | 18 +
 rtl/scratch_mem_arbiter.sv | 88 ++++++++
 tb/tb_scratch_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scratch_mem_arbiter_pkg.sv
// scratch_mem_arbiter_pkg: shared widths, requester indices, FSM encoding and RR pointer helper
// Ports: none (package); used by scratch_mem_arbiter and scratch_arb_select
package scratch_mem_arbiter_pkg;
    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;
    localparam int MEM_DEPTH_DEF = 256;
    localparam int REQ_HIST = 0;
    localparam int REQ_CDF = 1;
    localparam int REQ_DIV = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, RELEASE = 2'd2} arb_state_t;
    // highest-priority requester for the next arbitration: the one after the winner
    function automatic logic [1:0] next_ptr(input logic [2:0] win);
        return win[REQ_HIST] ? 2'd1 : win[REQ_CDF] ? 2'd2 : 2'd0;
    endfunction
endpackage

// File: rtl/scratch_arb_select.sv
// scratch_arb_select: one-hot winner among three requesters, ptr names the highest-priority index
// Ports: req[2:0] requests in, ptr[1:0] highest-priority index in, win[2:0] one-hot winner out
module scratch_arb_select
    import scratch_mem_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] win
);
    logic [2:0] rot;
    logic [2:0] pick;
    // rotate so ptr lands on bit0, pick the lowest set bit, rotate back
    always_comb begin
        rot = ptr == 2'd1 ? {req[0], req[2:1]} : ptr == 2'd2 ? {req[1:0], req[2]} : req;
        pick = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
        win = ptr == 2'd1 ? {pick[1:0], pick[2]} : ptr == 2'd2 ? {pick[0], pick[2:1]} : pick;
    end
endmodule

// File: rtl/scratch_mem_arbiter.sv
// scratch_mem_arbiter: burst arbiter giving histogram/cdf/divider exclusive use of one scratch RAM port
// Ports: clock, reset (async, active-high); req/we[2:0], addr0..2, wdata0..2 per requester;
//        fault_clear; gnt/rvalid[2:0] one-hot; rdata shared; mem_en/mem_we/mem_addr/mem_wdata/mem_rdata RAM port;
//        scratch_mem_overflow_fault sticky. Macro SCRATCH_ARB_RR_EN selects round-robin, else fixed priority.
module scratch_mem_arbiter
    import scratch_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    input  logic              fault_clear,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              scratch_mem_overflow_fault
);
    arb_state_t state_q, state_d;
    logic [2:0] gnt_q, gnt_d, rvalid_q, rvalid_d, win;
    logic fault_q, fault_d, own, ovf, sel_we;
    logic [1:0] ptr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
`ifdef SCRATCH_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = 2'd0;
`endif
    scratch_arb_select u_select (.req(req), .ptr(ptr), .win(win));
    always_comb begin
        own = state_q == OWN;
        sel_addr = gnt_q[REQ_CDF] ? addr1 : gnt_q[REQ_DIV] ? addr2 : addr0;
        sel_wdata = gnt_q[REQ_CDF] ? wdata1 : gnt_q[REQ_DIV] ? wdata2 : wdata0;
        sel_we = |(we & gnt_q);
        ovf = own && int'(sel_addr) >= MEM_DEPTH;
        mem_en = own && !ovf;
        mem_we = mem_en && sel_we;
        mem_addr = sel_addr;
        mem_wdata = sel_wdata;
        state_d = state_q == IDLE ? (|req ? OWN : IDLE) : own ? (|(req & gnt_q) ? OWN : RELEASE) : IDLE;
        gnt_d = state_q == IDLE ? win : own && |(req & gnt_q) ? gnt_q : 3'b000;
        // the owner tag travels with the read so it survives the grant dropping
        rvalid_d = mem_en && !sel_we ? gnt_q : 3'b000;
        fault_d = ovf || (fault_q && !fault_clear);
`ifdef SCRATCH_ARB_RR_EN
        ptr_d = state_q == IDLE && |req ? next_ptr(win) : ptr_q;
`endif
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q <= 3'b000;
            rvalid_q <= 3'b000;
            fault_q <= 1'b0;
`ifdef SCRATCH_ARB_RR_EN
            ptr_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            rvalid_q <= rvalid_d;
            fault_q <= fault_d;
`ifdef SCRATCH_ARB_RR_EN
            ptr_q <= ptr_d;
`endif
        end
    end
    assign gnt = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata = |rvalid_q ? mem_rdata : '0;
    assign scratch_mem_overflow_fault = fault_q;
endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// tb_scratch_mem_arbiter: directed and random checks of scratch_mem_arbiter against a burst-level model
module tb_scratch_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] we = 3'b000;
    logic [8:0] a[3];
    logic [15:0] wd[3];
    logic fault_clear = 1'b0;
    logic [2:0] gnt, rvalid;
    logic [15:0] rdata, mem_wdata;
    logic [15:0] mem_rdata = 16'd0;
    logic mem_en, mem_we, fault;
    logic [8:0] mem_addr;
    logic [15:0] ram [512] = '{default: '0};
    logic [15:0] ref_mem [256] = '{default: '0};
    int checks = 0;
    int errors = 0;
    int m_owner, m_prio, held;
    bit m_dead, m_fault;
    logic [2:0] m_rv;
    logic [15:0] m_rdv;

    scratch_mem_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .we(we),
        .addr0(a[0]), .addr1(a[1]), .addr2(a[2]),
        .wdata0(wd[0]), .wdata1(wd[1]), .wdata2(wd[2]),
        .fault_clear(fault_clear), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .scratch_mem_overflow_fault(fault)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_prio = 0;
        m_dead = 0;
        m_fault = 0;
        m_rv = 3'b000;
        m_rdv = 16'd0;
    endtask

    // one clock cycle: check outputs for the current inputs, then advance the model
    task automatic step();
        logic [2:0] eg;
        logic [8:0] oa;
        bit ovf, en, w;
        @(negedge clock);
        eg = 3'b000;
        oa = 9'd0;
        w = 0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            oa = a[m_owner];
            w = we[m_owner];
        end
        ovf = m_owner >= 0 && oa >= 9'd256;
        en = m_owner >= 0 && !ovf;
        chk("gnt", gnt, eg);
        chk("mem_en", mem_en, en);
        chk("mem_we", mem_we, en && w);
        if (en) chk("mem_addr", mem_addr, oa);
        if (en && w) chk("mem_wdata", mem_wdata, wd[m_owner]);
        chk("rvalid", rvalid, m_rv);
        chk("rdata", rdata, m_rv != 3'b000 ? m_rdv : 16'd0);
        chk("fault", fault, m_fault);
        if (en && w) ref_mem[oa[7:0]] = wd[m_owner];
        m_rv = 3'b000;
        if (en && !w) begin
            m_rv = eg;
            m_rdv = ref_mem[oa[7:0]];
        end
        m_fault = ovf || (m_fault && !fault_clear);
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_dead = 1;
            end
        end else if (m_dead) begin
            m_dead = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                int i = (m_prio + k) % 3;
                if (req[i] && m_owner < 0) begin
                    m_owner = i;
`ifdef SCRATCH_ARB_RR_EN
                    m_prio = (i + 1) % 3;
`endif
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            a[i] = 9'd0;
            wd[i] = 16'd0;
        end
        model_reset();
        #3;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_rvalid", rvalid, 3'b000);
        chk("rst_rdata", rdata, 16'd0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_fault", fault, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // histogram burst: writes 0..3 then read of address 2
        req = 3'b001;
        we = 3'b001;
        a[0] = 9'd0;
        wd[0] = 16'd10;
        step();
        for (int i = 0; i < 4; i++) begin
            a[0] = 9'(i);
            wd[0] = 16'(10 + i);
            step();
        end
        we = 3'b000;
        a[0] = 9'd2;
        step();
        chk("rd2_rvalid", rvalid, 3'b001);
        chk("rd2_rdata", rdata, 16'd12);
        req = 3'b000;
        repeat (3) step();

        // all requesters at once, owner drops, next one wins after the dead cycle
        req = 3'b111;
        step();
`ifndef SCRATCH_ARB_RR_EN
        chk("all_first", gnt, 3'b001);
`endif
        repeat (2) step();
        req = 3'b110;
        repeat (3) step();
`ifndef SCRATCH_ARB_RR_EN
        chk("all_second", gnt, 3'b010);
`endif
        req = 3'b000;
        repeat (4) step();

        // hist and cdf held, owner drops for one cycle after 4 owned cycles
        held = 0;
        for (int c = 0; c < 30; c++) begin
            req = 3'b011;
            if (m_owner >= 0 && held == 4) begin
                req[m_owner] = 1'b0;
                held = 0;
            end else if (m_owner >= 0) begin
                held++;
            end
            step();
        end
        req = 3'b000;
        repeat (4) step();

        // cdf overflow write, sticky fault, clear collision, clear
        req = 3'b010;
        we = 3'b010;
        a[1] = 9'd10;
        wd[1] = 16'h1234;
        repeat (2) step();
        a[1] = 9'd256;
        step();
        chk("ovf_set", fault, 1'b1);
        a[1] = 9'd11;
        repeat (2) step();
        chk("ovf_hold", fault, 1'b1);
        a[1] = 9'd300;
        fault_clear = 1'b1;
        step();
        chk("ovf_set_clr", fault, 1'b1);
        a[1] = 9'd12;
        step();
        fault_clear = 1'b0;
        chk("ovf_clr", fault, 1'b0);
        req = 3'b000;
        we = 3'b000;
        repeat (3) step();

        // read on the last granted cycle returns during the dead cycle
        req = 3'b001;
        we = 3'b001;
        a[0] = 9'd5;
        wd[0] = 16'hBEEF;
        repeat (2) step();
        req = 3'b000;
        we = 3'b000;
        step();
        chk("last_rd_gnt", gnt, 3'b000);
        chk("last_rd_rvalid", rvalid, 3'b001);
        chk("last_rd_rdata", rdata, 16'hBEEF);
        repeat (2) step();

        // reset mid-burst with a read in flight
        req = 3'b001;
        a[0] = 9'd3;
        repeat (2) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", gnt, 3'b000);
        chk("mid_rst_rvalid", rvalid, 3'b000);
        chk("mid_rst_mem_en", mem_en, 1'b0);
        chk("mid_rst_rdata", rdata, 16'd0);
        @(posedge clock);
        #1;
        chk("mid_rst_hold_rvalid", rvalid, 3'b000);
        reset = 1'b0;
        model_reset();
        repeat (2) step();
        chk("post_rst_gnt", gnt, 3'b001);
        req = 3'b000;
        repeat (3) step();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            req = 3'($urandom_range(0, 7));
            if (m_owner >= 0 && $urandom_range(0, 4) != 0) req[m_owner] = 1'b1;
            we = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                a[i] = 9'($urandom_range(0, 263));
                wd[i] = 16'($urandom);
            end
            fault_clear = $urandom_range(0, 9) == 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
